// File: rtl/operand_fetch.sv
// Operand fetch: scoreboarded register read with writeback bypass,
// holding one operand bundle for the ALU behind a valid/ready handshake.
module operand_fetch #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            src_a_sel,
    input  logic [1:0]            src_b_sel,
    input  logic [1:0]            dst_sel,
    input  logic                  dst_write,
    input  logic [DATA_WIDTH-1:0] reg_a_out,
    input  logic [DATA_WIDTH-1:0] reg_b_out,
    input  logic [DATA_WIDTH-1:0] reg_c_out,
    input  logic [DATA_WIDTH-1:0] reg_d_out,
    input  logic                  write_enable,
    input  logic [1:0]            select_reg,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b,
    output logic [1:0]            op_dst,
    output logic                  op_dst_write,
    output logic [3:0]            busy_mask,
    output logic [7:0]            stall_count
);

    logic [DATA_WIDTH-1:0] regs [4];
    logic [DATA_WIDTH-1:0] fetch_a;
    logic [DATA_WIDTH-1:0] fetch_b;
    logic [3:0]            busy_q;
    logic [3:0]            clr;
    logic [3:0]            live;
    logic [3:0]            set;
    logic [7:0]            stall_q;
    logic                  hazard;
    logic                  accept;

    assign regs[0] = reg_a_out;
    assign regs[1] = reg_b_out;
    assign regs[2] = reg_c_out;
    assign regs[3] = reg_d_out;

    // A writeback landing this cycle retires its scoreboard entry early.
    assign clr  = write_enable ? (4'b0001 << select_reg) : 4'b0000;
    assign live = busy_q & ~clr;

    assign hazard = live[src_a_sel] | live[src_b_sel]
                  | (dst_write & live[dst_sel]);

    assign req_ready = reset & (~op_valid | op_ready) & ~hazard;
    assign accept    = req_valid & req_ready;

    assign set = (accept && dst_write) ? (4'b0001 << dst_sel) : 4'b0000;

    assign fetch_a = clr[src_a_sel] ? alu_result : regs[src_a_sel];
    assign fetch_b = clr[src_b_sel] ? alu_result : regs[src_b_sel];

    assign busy_mask   = busy_q;
    assign stall_count = stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_valid     <= 1'b0;
            operand_a    <= '0;
            operand_b    <= '0;
            op_dst       <= 2'b00;
            op_dst_write <= 1'b0;
            busy_q       <= 4'b0000;
            stall_q      <= 8'd0;
        end else begin
            if (accept) begin
                op_valid     <= 1'b1;
                operand_a    <= fetch_a;
                operand_b    <= fetch_b;
                op_dst       <= dst_sel;
                op_dst_write <= dst_write;
            end else if (op_ready) begin
                op_valid <= 1'b0;
            end
            // Set after clear so a same-index reissue stays pending.
            busy_q <= (busy_q & ~clr) | set;
            if (req_valid && hazard && stall_q != 8'hFF) begin
                stall_q <= stall_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized and directed bench for operand_fetch against a
// behavioural scoreboard/bypass model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  src_a_sel, src_b_sel, dst_sel, select_reg;
    logic        dst_write, write_enable, op_ready;
    logic [15:0] reg_a_out, reg_b_out, reg_c_out, reg_d_out, alu_result;
    logic        op_valid, op_dst_write;
    logic [15:0] operand_a, operand_b;
    logic [1:0]  op_dst;
    logic [3:0]  busy_mask;
    logic [7:0]  stall_count;

    int checks = 0;
    int failures = 0;

    // Model state
    bit          m_busy [4];
    int          m_stall;
    bit          m_valid;
    logic [15:0] m_a, m_b;
    logic [1:0]  m_dst;
    bit          m_dw;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .dst_sel(dst_sel), .dst_write(dst_write),
        .reg_a_out(reg_a_out), .reg_b_out(reg_b_out),
        .reg_c_out(reg_c_out), .reg_d_out(reg_d_out),
        .write_enable(write_enable), .select_reg(select_reg),
        .alu_result(alu_result),
        .op_valid(op_valid), .op_ready(op_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .op_dst(op_dst), .op_dst_write(op_dst_write),
        .busy_mask(busy_mask), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit clears(input int r);
        return write_enable && (int'(select_reg) == r);
    endfunction

    function automatic logic [15:0] reg_val(input int r);
        case (r)
            0: return reg_a_out;
            1: return reg_b_out;
            2: return reg_c_out;
            default: return reg_d_out;
        endcase
    endfunction

    function automatic logic [15:0] fetch(input int r);
        return clears(r) ? alu_result : reg_val(r);
    endfunction

    function automatic bit pending(input int r);
        return m_busy[r] && !clears(r);
    endfunction

    function automatic bit m_hazard();
        return pending(src_a_sel) || pending(src_b_sel)
            || (dst_write && pending(dst_sel));
    endfunction

    function automatic logic [3:0] m_mask();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Inputs are set before call, away from the edge.
    task automatic cycle();
        bit hz, rdy, acc;
        #1;
        hz  = m_hazard();
        rdy = reset && (!m_valid || op_ready) && !hz;
        check("req_ready", req_ready, rdy);
        acc = req_valid && rdy;
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 4; i++) m_busy[i] = 0;
            m_stall = 0; m_valid = 0; m_a = 0; m_b = 0;
            m_dst = 0; m_dw = 0;
        end else begin
            if (acc) begin
                m_a = fetch(src_a_sel);
                m_b = fetch(src_b_sel);
                m_dst = dst_sel;
                m_dw = dst_write;
                m_valid = 1;
            end else if (op_ready) begin
                m_valid = 0;
            end
            if (write_enable) m_busy[select_reg] = 0;
            if (acc && dst_write) m_busy[dst_sel] = 1;
            if (req_valid && hz) m_stall = (m_stall + 1 > 255) ? 255 : m_stall + 1;
        end
        @(negedge clk);
        check("op_valid", op_valid, m_valid);
        check("operand_a", operand_a, m_a);
        check("operand_b", operand_b, m_b);
        check("op_dst", op_dst, m_dst);
        check("op_dst_write", op_dst_write, m_dw);
        check("busy_mask", busy_mask, m_mask());
        check("stall_count", stall_count, m_stall);
    endtask

    task automatic req(input bit v, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] d, input bit w);
        req_valid = v; src_a_sel = a; src_b_sel = b; dst_sel = d; dst_write = w;
    endtask

    task automatic wb(input bit we, input logic [1:0] sel, input logic [15:0] d);
        write_enable = we; select_reg = sel; alu_result = d;
    endtask

    initial begin
        reset = 1'b0; op_ready = 1'b1;
        req(0, 0, 0, 0, 0);
        wb(0, 0, 16'h0);
        reg_a_out = 16'h1111; reg_b_out = 16'h2222;
        reg_c_out = 16'h3333; reg_d_out = 16'h4444;
        m_valid = 0; m_stall = 0; m_a = 0; m_b = 0; m_dst = 0; m_dw = 0;
        for (int i = 0; i < 4; i++) m_busy[i] = 0;

        @(negedge clk);
        cycle(); cycle();
        check("rst_op_valid", op_valid, 0);
        check("rst_busy", busy_mask, 0);

        // Basic fetch
        reset = 1'b1;
        req(1, 2'b00, 2'b11, 2'b01, 1);
        cycle();
        check("basic_a", operand_a, 16'h1111);
        check("basic_b", operand_b, 16'h4444);
        check("basic_busy", busy_mask, 4'b0010);
        check("basic_valid", op_valid, 1);

        // RAW hazard on B, then released by bypassed writeback
        req(1, 2'b01, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) cycle();
        check("stall_3", stall_count, 3);
        wb(1, 2'b01, 16'hABCD);
        cycle();
        check("bypass_a", operand_a, 16'hABCD);
        check("bypass_busy", busy_mask, 4'b0000);
        wb(0, 0, 0);

        // Backpressure
        op_ready = 1'b0;
        req(1, 2'b00, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) cycle();
        check("frozen_a", operand_a, 16'hABCD);
        op_ready = 1'b1;
        req(1, 2'b10, 2'b10, 2'b00, 0);
        cycle();
        check("resume_a", operand_a, 16'h3333);
        check("resume_b", operand_b, 16'h3333);

        // Same-cycle clear and set on C
        req(1, 2'b00, 2'b00, 2'b10, 1);
        wb(1, 2'b10, 16'h5555);
        cycle();
        check("setwins", busy_mask[2], 1);
        wb(0, 0, 0);

        // Saturation
        req(1, 2'b10, 2'b00, 2'b00, 0);
        for (int i = 0; i < 300; i++) cycle();
        check("sat", stall_count, 255);

        // Build busy 1011 with a bundle valid, then reset
        req(0, 0, 0, 0, 0);
        wb(1, 2'b10, 16'h0);
        cycle();
        wb(0, 0, 0);
        req(1, 2'b10, 2'b10, 2'b00, 1); cycle();
        req(1, 2'b10, 2'b10, 2'b01, 1); cycle();
        req(1, 2'b10, 2'b10, 2'b11, 1); cycle();
        check("pre_rst_busy", busy_mask, 4'b1011);
        check("pre_rst_valid", op_valid, 1);
        reset = 1'b0;
        req(1, 2'b10, 2'b10, 2'b10, 1);
        wb(1, 2'b00, 16'h7777);
        cycle();
        check("rst_valid", op_valid, 0);
        check("rst_a", operand_a, 0);
        check("rst_mask", busy_mask, 0);
        check("rst_stall", stall_count, 0);
        reset = 1'b1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) != 0);
            req($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom),
                2'($urandom), $urandom_range(0, 2) != 0);
            wb($urandom_range(0, 2) == 0, 2'($urandom), 16'($urandom));
            op_ready = ($urandom_range(0, 3) != 0);
            reg_a_out = 16'($urandom); reg_b_out = 16'($urandom);
            reg_c_out = 16'($urandom); reg_d_out = 16'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
